// File: rtl/plot_sink_vga.sv
// Receiving end of the pixel-plot interface: 160x120x3 frame buffer, 4x-upscaled VGA scan-out
// with a clk/2 pixel enable, a self-timed buffer clear and a frame_start pacing pulse.
module plot_sink_vga #(
    parameter int         H_VIS        = 640,
    parameter int         H_FP         = 16,
    parameter int         H_SYNC       = 96,
    parameter int         H_BP         = 48,
    parameter int         V_VIS        = 480,
    parameter int         V_FP         = 10,
    parameter int         V_SYNC       = 2,
    parameter int         V_BP         = 33,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    input  logic       clear,
    output logic       clear_busy,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B
);
    localparam int          H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int          V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]  H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0]  HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam int          FB_SIZE  = 160 * 120;
    localparam logic [14:0] CLR_LAST = 15'(FB_SIZE - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t      state, state_next;
    logic [14:0] clr_addr;

    logic        pix_en;
    logic [9:0]  hc, vc;

    logic [14:0] rd_addr_p1;
    logic        hs_n_p1, vs_n_p1, vis_p1;
    logic [2:0]  rd_data_p2;
    logic        hs_n_p2, vs_n_p2, vis_p2;

    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;

    logic [2:0]  fb [0:FB_SIZE-1];

    // row*160 + col without a multiplier
    function automatic logic [14:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
        logic [14:0] r;
        r = {8'd0, row};
        return (r << 7) + (r << 5) + {7'd0, col};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= (state == SWEEP) ? clr_addr + 15'd1 : 15'd0;
        end
    end

    // The sweep owns the single write port; plots are dropped while it runs.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_addr    = fb_addr(y, x);
        wr_data    = colour;
        case (state)
            IDLE: begin
                if (clear) state_next = SWEEP;
                wr_en = plot && (x < 8'd160) && (y < 7'd120) && !reset;
            end
            SWEEP: begin
                wr_en   = !reset;
                wr_addr = clr_addr;
                wr_data = CLEAR_COLOUR;
                if (clr_addr == CLR_LAST) state_next = IDLE;
            end
        endcase
    end

    assign clear_busy = (state == SWEEP);

    always_ff @(posedge clk) begin
        if (wr_en) fb[wr_addr] <= wr_data;
    end

    // stage 2 read: a same-clk write to the same address is not seen until the next read
    always_ff @(posedge clk) begin
        if (reset)       rd_data_p2 <= '0;
        else if (pix_en) rd_data_p2 <= fb[rd_addr_p1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_en      <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            frame_start <= 1'b0;
            rd_addr_p1  <= '0;
            hs_n_p1     <= 1'b1;
            vs_n_p1     <= 1'b1;
            vis_p1      <= 1'b0;
            hs_n_p2     <= 1'b1;
            vs_n_p2     <= 1'b1;
            vis_p2      <= 1'b0;
        end else begin
            pix_en      <= !pix_en;
            frame_start <= 1'b0;
            if (pix_en) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    if (vc == V_LAST) begin
                        vc          <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        vc <= vc + 10'd1;
                    end
                end else begin
                    hc <= hc + 10'd1;
                end
                // stage 1: address and timing from the counters
                rd_addr_p1 <= fb_addr(vc[8:2], hc[9:2]);
                hs_n_p1    <= !((hc >= HS_BEG) && (hc < HS_END));
                vs_n_p1    <= !((vc >= VS_BEG) && (vc < VS_END));
                vis_p1     <= (hc < H_VIS_C) && (vc < V_VIS_C);
                // stage 2: timing aligned with the RAM read
                hs_n_p2    <= hs_n_p1;
                vs_n_p2    <= vs_n_p1;
                vis_p2     <= vis_p1;
            end
        end
    end

    assign VGA_CLK     = pix_en;
    assign VGA_HS      = hs_n_p2;
    assign VGA_VS      = vs_n_p2;
    assign VGA_BLANK_N = vis_p2;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_R       = vis_p2 ? {10{rd_data_p2[2]}} : 10'd0;
    assign VGA_G       = vis_p2 ? {10{rd_data_p2[1]}} : 10'd0;
    assign VGA_B       = vis_p2 ? {10{rd_data_p2[0]}} : 10'd0;
endmodule
